fsk_modulator_nco: RTL and testbench
====================================

FSK_MODULATOR_NCO -- requirements
Module: fsk_modulator_nco

Interface
REQ-001 SHALL have parameter DW, default 8: output sample width in bits.
REQ-002 SHALL have parameter PW, default 16: phase accumulator and tuning-word width in bits.
REQ-003 SHALL have parameter LUT_AW, default 5: sine table address bits; the table holds 2^LUT_AW entries per cycle.
REQ-004 SHALL have parameter SW, default 16: symbol-length counter width in bits.
REQ-005 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port sample_en  input  1: sample tick; one output sample is produced per cycle in which it is high.
REQ-008 SHALL have port bit_valid  input  1: a data bit is offered.
REQ-009 SHALL have port bit_data  input  1: the offered bit; 1 is mark, 0 is space.
REQ-010 SHALL have port bit_ready  output  1: the block accepts the offered bit this cycle.
REQ-011 SHALL have port tw_mark  input  PW: phase increment per sample for mark.
REQ-012 SHALL have port tw_space  input  PW: phase increment per sample for space.
REQ-013 SHALL have port sym_len  input  SW: samples per symbol.
REQ-014 SHALL have port saida  output  DW: unsigned offset-binary sine sample.
REQ-015 SHALL have port busy  output  1: high while a symbol is being transmitted.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and RUN.
REQ-017 In IDLE: bit_ready=1, busy=0, phase accumulator=0, saida=2^(DW-1).
REQ-018 IDLE->RUN on bit_valid&bit_ready; the block latches bit_data, latches the selected tuning word (tw_mark or tw_space), and loads the symbol counter with sym_len-1.
REQ-019 A sym_len of 0 SHALL be treated as 1.
REQ-020 In RUN, on each cycle with sample_en=1, the block registers saida<=LUT(phase[PW-1:PW-LUT_AW]), then sets phase<=phase+tw modulo 2^PW and decrements the symbol counter; saida shows the sample one cycle after the tick.
REQ-021 In RUN with sample_en=0, the phase, counter and saida SHALL hold.
REQ-022 LUT(k) SHALL equal 2^(DW-1)+round((2^(DW-1)-1)*sin(2*pi*k/2^LUT_AW)), rounding half away from zero; a quarter-wave table with symmetry folding is permitted if the values match exactly.
REQ-023 In RUN, bit_ready SHALL equal (symbol counter==0)&sample_en, driven combinationally, so the next bit is taken on the final tick of the current symbol.
REQ-024 On acceptance in RUN, the block stays in RUN, reloads the counter and tuning word, and does NOT reset the phase (continuous-phase switching); the new frequency applies from the next tick, with no gap sample.
REQ-025 On the final tick without acceptance: RUN->IDLE next cycle, saida returns to 2^(DW-1) that cycle, and the phase clears to 0.
REQ-026 Changes to tw_mark, tw_space or sym_len during a symbol SHALL NOT affect that symbol.
REQ-027 busy=1 exactly while in RUN.
REQ-028 Tuning-word sums SHALL wrap modulo 2^PW without saturation.

Reset
REQ-029 reset=1 SHALL, at the next clock edge, force IDLE, phase=0, symbol counter=0, latched bit and tuning word=0, and saida=2^(DW-1), regardless of state or sample_en.
REQ-030 A reset asserted mid-symbol SHALL discard the symbol; bit_ready=1 in the first cycle after reset deasserts.
REQ-031 No initial blocks SHALL be relied on; all state comes from reset.

Verification (DW=8, PW=16, LUT_AW=5, sample_en=1 unless stated)
REQ-032 Reset held 2 cycles -> saida=128, bit_ready=1, busy=0.
REQ-033 Space bit, tw_space=2048, sym_len=32 -> saida 128,153,177,199,218,234,245,253,255,... 32 samples (one cycle), then 128 with busy=0.
REQ-034 Mark bit, tw_mark=4096, sym_len=32 -> saida 128,177,218,245,255,245,218,177,128,79,... two full cycles in 32 samples.
REQ-035 Bits 0 then 1 back-to-back, tw_space=8192, tw_mark=16384, sym_len=4 -> saida 128,255,128,1 | 128,1,128,255; bit_ready high only on the 4th tick; no idle sample in between.
REQ-036 sample_en pulsed every 3rd cycle during a symbol -> saida changes only the cycle after each tick; the sample sequence is the same as in REQ-033.
REQ-037 reset asserted on the 10th sample of a symbol -> next cycle saida=128, busy=0; a new space bit restarts at 128,153.

Source files
------------

// File: rtl/fsk_modulator_nco.sv
// Continuous-phase binary FSK modulator built on a phase-accumulator NCO.
// Each accepted bit is sent as sym_len samples of a sine whose frequency is
// set by tw_mark or tw_space. Back-to-back bits keep the phase running.
module fsk_modulator_nco #(
  parameter int DW     = 8,
  parameter int PW     = 16,
  parameter int LUT_AW = 5,
  parameter int SW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_en,
  input  logic          bit_valid,
  input  logic          bit_data,
  output logic          bit_ready,
  input  logic [PW-1:0] tw_mark,
  input  logic [PW-1:0] tw_space,
  input  logic [SW-1:0] sym_len,
  output logic [DW-1:0] saida,
  output logic          busy
);

  localparam int LUT_N = 2 ** LUT_AW;
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One full sine period in offset binary, rounded half away from zero.
  function automatic logic [DW-1:0] lut_val(input int k);
    real amp;
    real a;
    real r;
    amp = (2.0 ** (DW - 1)) - 1.0;
    a   = amp * $sin(2.0 * 3.14159265358979323846 * k / LUT_N);
    if (a >= 0.0) begin
      r = $floor(a + 0.5);
    end else begin
      r = -$floor(-a + 0.5);
    end
    return DW'((2 ** (DW - 1)) + $rtoi(r));
  endfunction

  logic [DW-1:0] lut_s [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign lut_s[k] = lut_val(k);
  end

  state_t        state_r;
  state_t        state_nxt_s;
  logic [PW-1:0] phase_r;
  logic [SW-1:0] cnt_r;
  logic          bit_r;
  logic [PW-1:0] twm_r;
  logic [PW-1:0] tws_r;
  logic [DW-1:0] saida_r;

  logic          tick_s;
  logic          last_s;
  logic          accept_s;
  logic [PW-1:0] tw_s;
  logic [SW-1:0] cnt_load_s;

  // Handshake and datapath decode; the next bit is taken on the final tick.
  always_comb begin
    tick_s     = (state_r == RUN) && sample_en;
    last_s     = tick_s && (cnt_r == '0);
    bit_ready  = (state_r == IDLE) || last_s;
    accept_s   = bit_valid && bit_ready;
    // The symbol's frequency is fixed by the bit and words captured at acceptance.
    tw_s       = bit_r ? twm_r : tws_r;
    // A zero length still produces one sample.
    cnt_load_s = (sym_len == '0) ? '0 : (sym_len - SW'(1));
  end

  // Next-state logic for the IDLE/RUN controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s && !accept_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, symbol capture, NCO phase, symbol counter and output sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      phase_r <= '0;
      cnt_r   <= '0;
      bit_r   <= 1'b0;
      twm_r   <= '0;
      tws_r   <= '0;
      saida_r <= MID;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        bit_r <= bit_data;
        twm_r <= tw_mark;
        tws_r <= tw_space;
      end
      if (state_r == IDLE) begin
        phase_r <= '0;
        saida_r <= MID;
        if (accept_s) begin
          cnt_r <= cnt_load_s;
        end
      end else if (tick_s) begin
        saida_r <= lut_s[phase_r[PW-1 -: LUT_AW]];
        if (cnt_r == '0) begin
          if (accept_s) begin
            // Continuous-phase hand-over: keep accumulating, new word applies next tick.
            phase_r <= phase_r + tw_s;
            cnt_r   <= cnt_load_s;
          end else begin
            phase_r <= '0;
            cnt_r   <= '0;
          end
        end else begin
          phase_r <= phase_r + tw_s;
          cnt_r   <= cnt_r - SW'(1);
        end
      end
    end
  end

  assign saida = saida_r;
  assign busy  = (state_r == RUN);

endmodule

// File: tb/tb_fsk_modulator_nco.sv
// Bench for fsk_modulator_nco: directed scenarios plus randomized traffic,
// checked against a symbol-level model that precomputes each symbol's samples.
module tb_fsk_modulator_nco;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic        bit_valid;
  logic        bit_data;
  logic        bit_ready;
  logic [15:0] tw_mark;
  logic [15:0] tw_space;
  logic [15:0] sym_len;
  logic [7:0]  saida;
  logic        busy;

  fsk_modulator_nco #(.DW(8), .PW(16), .LUT_AW(5), .SW(16)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .bit_valid(bit_valid),
    .bit_data(bit_data), .bit_ready(bit_ready), .tw_mark(tw_mark),
    .tw_space(tw_space), .sym_len(sym_len), .saida(saida), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference sine table: 128 + round(127*sin(2*pi*k/32)).
  int lut_m [32] = '{128, 153, 177, 199, 218, 234, 245, 253,
                     255, 253, 245, 234, 218, 199, 177, 153,
                     128, 103,  79,  57,  38,  22,  11,   3,
                       1,   3,  11,  22,  38,  57,  79, 103};

  int total = 0;
  int bad   = 0;
  int exp_q [$];
  int rem   = 0;
  int mphase = 0;
  bit pend  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: check what the last edge produced, then drive and model.
  task automatic step(input logic rs, input logic se, input logic bv, input logic bd,
                      input logic [15:0] twm, input logic [15:0] tws, input logic [15:0] sl);
    int n;
    int t;
    int rem_before;
    @(negedge clk);
    if (pend) begin
      if (exp_q.size() == 0) begin
        check_val("sample_queue_empty", 32'd1, 32'd0);
      end else begin
        check_val("sample", {24'd0, saida}, exp_q.pop_front());
      end
    end else if (!busy) begin
      check_val("idle_saida", {24'd0, saida}, 32'd128);
    end
    check_val("busy", {31'd0, busy}, {31'd0, (rem > 0)});
    if (rem == 0) check_val("ready_idle", {31'd0, bit_ready}, 32'd1);
    pend = 1'b0;

    reset = rs; sample_en = se; bit_valid = bv; bit_data = bd;
    tw_mark = twm; tw_space = tws; sym_len = sl;
    #1;
    if (rs) begin
      exp_q.delete();
      rem = 0;
      mphase = 0;
    end else begin
      rem_before = rem;
      if (rem_before > 0)
        check_val("ready_run", {31'd0, bit_ready}, {31'd0, (se && rem_before == 1)});
      if (rem_before > 0 && se) begin
        pend = 1'b1;
        rem--;
      end
      if (bv && (rem_before == 0 || (se && rem_before == 1))) begin
        n = (sl == 16'd0) ? 1 : int'(sl);
        t = bd ? int'(twm) : int'(tws);
        if (rem_before == 0) mphase = 0;
        for (int i = 0; i < n; i++) begin
          exp_q.push_back(lut_m[mphase >> 11]);
          mphase = (mphase + t) & 32'hFFFF;
        end
        rem = n;
      end
    end
  endtask

  task automatic idle_steps(input int cnt, input logic se);
    for (int i = 0; i < cnt; i++)
      step(1'b0, se, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b1; bit_valid = 1'b0; bit_data = 1'b0;
    tw_mark = 16'd0; tw_space = 16'd0; sym_len = 16'd0;
    repeat (2) @(posedge clk);

    // Reset release: idle output, ready, not busy.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd32);
    idle_steps(2, 1'b1);

    // Space bit, one sine cycle over 32 samples; inputs wander mid-symbol.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd2048, 16'd32);
    idle_steps(36, 1'b1);

    // Mark bit, two cycles over 32 samples.
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'd4096, 16'd0, 16'd32);
    idle_steps(36, 1'b1);

    // Space then mark back-to-back, 4 samples each.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'd16384, 16'd8192, 16'd4);
    idle_steps(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'd16384, 16'd8192, 16'd4);
    idle_steps(8, 1'b1);

    // Space bit with a tick only every third cycle.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd2048, 16'd32);
    for (int i = 0; i < 110; i++)
      step(1'b0, (i % 3 == 0), 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));

    // Reset on the 10th sample, then a fresh space bit.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd2048, 16'd32);
    idle_steps(9, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd2048, 16'd32);
    idle_steps(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd2048, 16'd32);
    idle_steps(36, 1'b1);

    // Zero length behaves as one sample.
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'd8192, 16'd0, 16'd0);
    idle_steps(4, 1'b1);

    // Randomized traffic with wrapping tuning words and occasional resets.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), 1'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom_range(0, 6)));
    idle_steps(12, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
